// File: rtl/run_pattern_tx.sv
// rtl/run_pattern_tx.sv - serial run-length pattern transmitter with two-ones hit counter
//
// Each accepted command emits io_cmd_ones 1-bits followed by io_cmd_zeros 0-bits,
// one bit per clock. A shadow two-consecutive-ones detector watches io_out and
// keeps a saturating hit count.
//
// Ports:
//   clock, reset        single clock, synchronous active-high reset
//   io_cmd_valid/ready  command handshake (accepted when both high at posedge)
//   io_cmd_ones/zeros   run lengths of the command
//   io_clear            synchronous clear of io_hits (wins over a hit)
//   io_out              serial bit, 0 when not emitting
//   io_out_valid        io_out carries a command bit
//   io_busy             a command is being emitted
//   io_hits             saturating count of detector hits

module run_pattern_tx #(
  parameter int CNT_W = 4,
  parameter int HIT_W = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             io_cmd_valid,
  output logic             io_cmd_ready,
  input  logic [CNT_W-1:0] io_cmd_ones,
  input  logic [CNT_W-1:0] io_cmd_zeros,
  input  logic             io_clear,
  output logic             io_out,
  output logic             io_out_valid,
  output logic             io_busy,
  output logic [HIT_W-1:0] io_hits
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ONES  = 2'd1,
    ZEROS = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] remaining_q, remaining_d;
  logic [CNT_W-1:0] zeros_q, zeros_d;
  logic [1:0]       run_q;
  logic [HIT_W-1:0] hits_q;

  logic rem_one;
  logic last_bit;
  logic accept;
  logic hit;

  assign rem_one  = (remaining_q == CNT_W'(1));
  // Last bit of the current command: a new command may be taken here so
  // its first bit follows without a gap.
  assign last_bit = ((state_q == ONES) && rem_one && (zeros_q == '0)) ||
                    ((state_q == ZEROS) && rem_one);

  assign io_cmd_ready = (state_q == IDLE) || last_bit;
  assign accept       = io_cmd_valid && io_cmd_ready;

  assign io_out       = (state_q == ONES);
  assign io_out_valid = (state_q == ONES) || (state_q == ZEROS);
  assign io_busy      = io_out_valid;
  assign io_hits      = hits_q;

  // A hit is a 1 bit arriving while the previous bit was also a 1.
  assign hit = io_out && (run_q != 2'd0);

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      remaining_q <= '0;
      zeros_q     <= '0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      zeros_q     <= zeros_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    zeros_d     = zeros_q;

    case (state_q)
      ONES: begin
        if (!rem_one) begin
          remaining_d = remaining_q - CNT_W'(1);
        end else if (zeros_q != '0) begin
          state_d     = ZEROS;
          remaining_d = zeros_q;
          zeros_d     = '0;
        end else begin
          state_d     = IDLE;
          remaining_d = '0;
        end
      end
      ZEROS: begin
        if (!rem_one) begin
          remaining_d = remaining_q - CNT_W'(1);
        end else begin
          state_d     = IDLE;
          remaining_d = '0;
        end
      end
      default: begin
        state_d     = IDLE;
        remaining_d = '0;
        zeros_d     = '0;
      end
    endcase

    // Accept overrides the end-of-command fallthrough; ready only rises in
    // IDLE or on the last bit, so nothing in flight is lost.
    if (accept) begin
      if (io_cmd_ones != '0) begin
        state_d     = ONES;
        remaining_d = io_cmd_ones;
        zeros_d     = io_cmd_zeros;
      end else if (io_cmd_zeros != '0) begin
        state_d     = ZEROS;
        remaining_d = io_cmd_zeros;
        zeros_d     = '0;
      end else begin
        state_d     = IDLE;
        remaining_d = '0;
        zeros_d     = '0;
      end
    end
  end

  // Shadow detector: run counts consecutive ones, saturating at 2.
  // Idle cycles present io_out=0 and so break the run.
  always_ff @(posedge clock) begin
    if (reset) begin
      run_q <= 2'd0;
    end else if (io_out) begin
      run_q <= run_q[1] ? 2'd2 : run_q + 2'd1;
    end else begin
      run_q <= 2'd0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || io_clear) begin
      hits_q <= '0;
    end else if (hit && !(&hits_q)) begin
      hits_q <= hits_q + HIT_W'(1);
    end
  end

endmodule

// File: tb/tb_run_pattern_tx.sv
// tb/tb_run_pattern_tx.sv - directed self-checking bench for run_pattern_tx

module tb_run_pattern_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic       io_cmd_valid;
  logic       io_cmd_ready;
  logic [3:0] io_cmd_ones;
  logic [3:0] io_cmd_zeros;
  logic       io_clear;
  logic       io_out;
  logic       io_out_valid;
  logic       io_busy;
  logic [7:0] io_hits;

  int n_checks = 0;
  int n_fail   = 0;

  run_pattern_tx #(.CNT_W(4), .HIT_W(8)) dut (
    .clock        (clock),
    .reset        (reset),
    .io_cmd_valid (io_cmd_valid),
    .io_cmd_ready (io_cmd_ready),
    .io_cmd_ones  (io_cmd_ones),
    .io_cmd_zeros (io_cmd_zeros),
    .io_clear     (io_clear),
    .io_out       (io_out),
    .io_out_valid (io_out_valid),
    .io_busy      (io_busy),
    .io_hits      (io_hits)
  );

  always #5 clock = ~clock;

  task automatic expect_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  // Advance one cycle; inputs are driven and outputs sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input int ones, input int zeros);
    io_cmd_valid = 1'b1;
    io_cmd_ones  = 4'(ones);
    io_cmd_zeros = 4'(zeros);
  endtask

  task automatic clear_hits();
    io_clear = 1'b1;
    tick();
    io_clear = 1'b0;
  endtask

  initial begin
    logic [4:0] exp_out;
    logic [4:0] exp_rdy;

    reset        = 1'b1;
    io_cmd_valid = 1'b0;
    io_cmd_ones  = '0;
    io_cmd_zeros = '0;
    io_clear     = 1'b0;
    tick();
    tick();
    reset = 1'b0;

    // Reset / idle state
    expect_eq("rst_ready", io_cmd_ready, 1);
    expect_eq("rst_out", io_out, 0);
    expect_eq("rst_out_valid", io_out_valid, 0);
    expect_eq("rst_busy", io_busy, 0);
    expect_eq("rst_hits", io_hits, 0);

    // (3,2): 1,1,1,0,0 ; ready low on cycles 1..4, high on 5 ; hits=2 at 6
    exp_out = 5'b00111;
    exp_rdy = 5'b10000;
    send(3, 2);
    tick();
    io_cmd_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      expect_eq($sformatf("c32_out_%0d", k + 1), io_out, int'(exp_out[k]));
      expect_eq($sformatf("c32_rdy_%0d", k + 1), io_cmd_ready, int'(exp_rdy[k]));
      expect_eq($sformatf("c32_ov_%0d", k + 1), io_out_valid, 1);
      expect_eq($sformatf("c32_busy_%0d", k + 1), io_busy, 1);
      tick();
    end
    expect_eq("c32_hits", io_hits, 2);
    expect_eq("c32_ov_end", io_out_valid, 0);
    clear_hits();
    expect_eq("clr_hits", io_hits, 0);

    // (1,0),(1,0) back to back -> 1,1 and one hit
    send(1, 0);
    tick();
    expect_eq("b2b_out1", io_out, 1);
    expect_eq("b2b_rdy1", io_cmd_ready, 1);
    tick();
    io_cmd_valid = 1'b0;
    expect_eq("b2b_out2", io_out, 1);
    tick();
    expect_eq("b2b_ov3", io_out_valid, 0);
    expect_eq("b2b_hits", io_hits, 1);

    // (0,0) consumed without emitting; hits unchanged
    send(0, 0);
    expect_eq("z_rdy0", io_cmd_ready, 1);
    tick();
    io_cmd_valid = 1'b0;
    expect_eq("z_ov", io_out_valid, 0);
    expect_eq("z_busy", io_busy, 0);
    expect_eq("z_rdy1", io_cmd_ready, 1);
    expect_eq("z_hits", io_hits, 1);
    clear_hits();

    // (1,1),(1,0) -> 1,0,1 with no hits
    send(1, 1);
    tick();
    expect_eq("s_out1", io_out, 1);
    expect_eq("s_rdy1", io_cmd_ready, 0);
    send(1, 0);
    tick();
    expect_eq("s_out2", io_out, 0);
    expect_eq("s_ov2", io_out_valid, 1);
    expect_eq("s_rdy2", io_cmd_ready, 1);
    tick();
    io_cmd_valid = 1'b0;
    expect_eq("s_out3", io_out, 1);
    tick();
    expect_eq("s_ov4", io_out_valid, 0);
    expect_eq("s_hits", io_hits, 0);

    // 18 back-to-back (15,0): 14 hits then 15 each, saturating at 255
    send(15, 0);
    for (int c = 1; c <= 271; c++) begin
      tick();
      if (c > 255) io_cmd_valid = 1'b0;
      if (c == 16)  expect_eq("sat_hits16", io_hits, 14);
      if (c == 30)  expect_eq("sat_rdy30", io_cmd_ready, 1);
      if (c == 31)  begin
        expect_eq("sat_rdy31", io_cmd_ready, 0);
        expect_eq("sat_hits31", io_hits, 29);
      end
      if (c == 100) expect_eq("sat_out100", io_out, 1);
      if (c == 256) expect_eq("sat_hits256", io_hits, 254);
      if (c == 257) expect_eq("sat_hits257", io_hits, 255);
      if (c == 270) expect_eq("sat_out270", io_out, 1);
    end
    expect_eq("sat_ov_end", io_out_valid, 0);
    expect_eq("sat_hits_end", io_hits, 255);

    // io_clear on a hit cycle wins; counting resumes next hit
    send(15, 0);
    tick();
    io_cmd_valid = 1'b0;
    tick();
    tick();
    io_clear = 1'b1;
    tick();
    io_clear = 1'b0;
    expect_eq("clrhit_hits", io_hits, 0);
    tick();
    expect_eq("clrhit_next", io_hits, 1);
    for (int c = 0; c < 14; c++) tick();
    expect_eq("clrhit_idle", io_out_valid, 0);

    // (5,5) with reset on the 2nd bit, then (2,0) -> one hit
    send(5, 5);
    tick();
    io_cmd_valid = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    expect_eq("mrst_out", io_out, 0);
    expect_eq("mrst_ov", io_out_valid, 0);
    expect_eq("mrst_rdy", io_cmd_ready, 1);
    expect_eq("mrst_hits", io_hits, 0);
    send(2, 0);
    tick();
    io_cmd_valid = 1'b0;
    tick();
    tick();
    expect_eq("mrst_ov_end", io_out_valid, 0);
    expect_eq("mrst_hits2", io_hits, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
